uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: recovers 8-N-1 serial frames (one start bit, DATA_BITS data bits LSB first, one stop bit, no parity) from the asynchronous line rx_i. It uses the shared 16x-baud sample_tick_i strobe. It is the receiving end paired with the team's UART transmitter and sits between the board RX pin and the command/data parser. Each completed frame is presented as a parallel word with a one-cycle done strobe and a framing-error flag.

## Interface
- DATA_BITS, 8: data bits per frame.
- STOP_SAMPLE, 11: ticks counted after the last data-bit sample before the stop bit is sampled. Sampling happens on tick STOP_SAMPLE+1, which is 4 ticks into the stop bit and is compatible with the 8-tick stop bit of the companion transmitter.
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low; clock clk_i.
- sample_tick_i  in  1  one-clk_i-cycle strobe at 16x baud rate.
- rx_i  in  1  serial line, idle high, asynchronous to clk_i.
- rx_data_o  out  DATA_BITS  last received word.
- rx_done_tick_o  out  1  one-cycle pulse when a frame completes.
- frame_err_o  out  1  stop bit of the last frame sampled low.
- rx_busy_o  out  1  high in every state except S_IDLE.

## Operation
- rx_i passes through a 2-flop synchronizer; both flops reset to 1. All FSM decisions use the synchronized value rx_s.
- Registers:
  - state: S_IDLE, S_START, S_DATA, S_STOP.
  - tick counter: 4 bits.
  - bit counter: 3 bits, sized for DATA_BITS ≤ 8.
  - shift register: DATA_BITS wide.
- S_IDLE:
  - If rx_s==0, go to S_START and clear the tick counter.
  - Reacts on any clk_i cycle; does not wait for a tick.
- S_START:
  - On each tick, increment the tick counter.
  - On the tick where the counter==7 (mid start bit):
    - if rx_s==0: go to S_DATA, clear the tick and bit counters;
    - else: false start (glitch), return to S_IDLE with no outputs changed.
- S_DATA:
  - On the tick where the counter==15 (mid data bit): shift = {rx_s, shift[DATA_BITS-1:1]} (LSB first) and clear the tick counter.
  - If the bit counter==DATA_BITS-1, go to S_STOP; else increment the bit counter.
- S_STOP:
  - On the tick where the counter==STOP_SAMPLE:
    - load rx_data_o from shift;
    - set frame_err_o = ~rx_s;
    - pulse rx_done_tick_o;
    - go to S_IDLE.
  - Otherwise increment the tick counter on each tick.
- The frame is delivered even on a framing error; frame_err_o marks it.
- rx_data_o and frame_err_o hold their values until the next completed frame.
- No consumer handshake exists. A downstream block must capture on rx_done_tick_o.
- Illegal state encoding: return to S_IDLE.

## Timing
- Reset values:
  - rx_data_o=0, rx_done_tick_o=0, frame_err_o=0, rx_busy_o=0;
  - state S_IDLE, all counters 0, synchronizer flops 1.
- rx_done_tick_o, rx_data_o and frame_err_o are registered. They change together, one clk_i after the clock edge on which the final stop tick was seen. rx_done_tick_o is high for exactly one cycle.
- Latency from the rx_s falling edge to rx_done_tick_o: 8 + 16·DATA_BITS + (STOP_SAMPLE+1) ticks, i.e. 148 ticks at the defaults, plus at most 1 clk_i.
- The synchronizer adds a 2-cycle delay from rx_i to rx_s.
- Back-to-back frames: S_IDLE is re-entered mid stop bit. The next start edge is detected immediately, so no idle gap is required beyond the stop bit.
- sample_tick_i asserted every cycle is legal; the FSM then advances one tick per clk_i.
- Reset asserted mid-frame: everything returns to reset values at once. No done pulse is produced for the partial frame. After release, the receiver waits in S_IDLE for a falling edge. If the line is low at release, that low level is treated as a start.

## Test plan
- Tick every 4 clk_i; send 0x55 with a valid stop bit -> one rx_done_tick_o pulse, rx_data_o=0x55, frame_err_o=0, 148 ticks after the start edge.
- Companion transmitter looped to rx_i; send 0xA5, 0x00, 0xFF back-to-back -> three done pulses with data 0xA5, 0x00, 0xFF, all with frame_err_o=0.
- Low glitch of 4 ticks on an idle line -> no done pulse, return to S_IDLE; rx_data_o keeps its previous value.
- Frame 0x3C with the stop bit driven low -> done pulse, rx_data_o=0x3C, frame_err_o=1. A following good frame 0x12 -> frame_err_o=0.
- rst_ni asserted during data bit 3 of 0xC3, released, then 0x7E sent -> outputs at reset values during reset, no pulse for the 0xC3 fragment, rx_data_o=0x7E after the second frame.
- sample_tick_i tied high; send 0x81 -> rx_data_o=0x81 after 148 clk_i (+2 sync cycles), with a single-cycle done pulse.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver driven by a shared 16x-baud sample strobe.
// The line is synchronised, the start bit is confirmed at its midpoint, data
// bits are sampled mid-bit LSB first, and the stop bit is sampled a few ticks
// into its period so the receiver is back in S_IDLE early enough for
// back-to-back frames. Each completed frame updates the data word and the
// framing-error flag, and pulses the done strobe for one cycle.
`timescale 1ns/1ps

module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_SAMPLE = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sample_tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_done_tick_o,
    output logic                 frame_err_o,
    output logic                 rx_busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // Mid start bit, mid data bit, stop-bit sample point and last data index.
    localparam logic [3:0] TICK_MID  = 4'd7;
    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [3:0] STOP_TICK = 4'(STOP_SAMPLE);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    // Synchroniser flops; both idle high so reset looks like an idle line.
    logic                 sync_meta_r;
    logic                 sync_r;
    logic                 rx_s;

    // FSM state and datapath registers.
    state_e               state_r;
    state_e               state_next_s;
    logic [3:0]           tick_cnt_r;
    logic [3:0]           tick_cnt_next_s;
    logic [2:0]           bit_cnt_r;
    logic [2:0]           bit_cnt_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;

    // Registered outputs.
    logic [DATA_BITS-1:0] data_r;
    logic [DATA_BITS-1:0] data_next_s;
    logic                 done_r;
    logic                 done_next_s;
    logic                 err_r;
    logic                 err_next_s;
    logic                 busy_r;

    assign rx_s = sync_r;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_meta_r <= 1'b1;
            sync_r      <= 1'b1;
        end else begin
            sync_meta_r <= rx_i;
            sync_r      <= sync_meta_r;
        end
    end

    // Next-state and datapath decode; all decisions use the synchronised line.
    always_comb begin
        state_next_s    = state_r;
        tick_cnt_next_s = tick_cnt_r;
        bit_cnt_next_s  = bit_cnt_r;
        shift_next_s    = shift_r;
        data_next_s     = data_r;
        done_next_s     = 1'b0;
        err_next_s      = err_r;

        case (state_r)
            S_IDLE: begin
                // Start edge is recognised on any clock, not only on a tick.
                if (rx_s == 1'b0) begin
                    state_next_s    = S_START;
                    tick_cnt_next_s = 4'd0;
                end else begin
                    state_next_s    = S_IDLE;
                end
            end

            S_START: begin
                if (sample_tick_i) begin
                    if (tick_cnt_r == TICK_MID) begin
                        if (rx_s == 1'b0) begin
                            state_next_s    = S_DATA;
                            tick_cnt_next_s = 4'd0;
                            bit_cnt_next_s  = 3'd0;
                        end else begin
                            // Line recovered before mid start bit: a glitch.
                            state_next_s    = S_IDLE;
                        end
                    end else begin
                        tick_cnt_next_s = tick_cnt_r + 4'd1;
                    end
                end else begin
                    state_next_s = S_START;
                end
            end

            S_DATA: begin
                if (sample_tick_i) begin
                    if (tick_cnt_r == TICK_LAST) begin
                        tick_cnt_next_s = 4'd0;
                        shift_next_s    = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            state_next_s = S_STOP;
                        end else begin
                            bit_cnt_next_s = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        tick_cnt_next_s = tick_cnt_r + 4'd1;
                    end
                end else begin
                    state_next_s = S_DATA;
                end
            end

            S_STOP: begin
                if (sample_tick_i) begin
                    if (tick_cnt_r == STOP_TICK) begin
                        // Frame is delivered even when the stop bit is bad.
                        data_next_s  = shift_r;
                        err_next_s   = ~rx_s;
                        done_next_s  = 1'b1;
                        state_next_s = S_IDLE;
                    end else begin
                        tick_cnt_next_s = tick_cnt_r + 4'd1;
                    end
                end else begin
                    state_next_s = S_STOP;
                end
            end

            default: begin
                state_next_s    = S_IDLE;
                tick_cnt_next_s = 4'd0;
                bit_cnt_next_s  = 3'd0;
            end
        endcase
    end

    // State, counter, shift and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= S_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= '0;
            data_r     <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tick_cnt_r <= tick_cnt_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
            data_r     <= data_next_s;
            done_r     <= done_next_s;
            err_r      <= err_next_s;
            // Registered copy that tracks "state is not S_IDLE".
            busy_r     <= (state_next_s != S_IDLE);
        end
    end

    assign rx_data_o      = data_r;
    assign rx_done_tick_o = done_r;
    assign frame_err_o    = err_r;
    assign rx_busy_o      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomised frames for uart_rx. A bench-side
// transmitter drives rx_i; a reference model predicts, for every complete
// frame, the delivered word, the error flag and the arrival time in ticks.
`timescale 1ns/1ps

module tb_uart_rx;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       sample_tick_i = 1'b0;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       rx_done_tick_o;
    logic       frame_err_o;
    logic       rx_busy_o;

    uart_rx #(.DATA_BITS(8), .STOP_SAMPLE(11)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sample_tick_i  (sample_tick_i),
        .rx_i           (rx_i),
        .rx_data_o      (rx_data_o),
        .rx_done_tick_o (rx_done_tick_o),
        .frame_err_o    (frame_err_o),
        .rx_busy_o      (rx_busy_o)
    );

    // Reference timing: start edge to done is 8 + 16*8 + 12 ticks once the
    // receiver sees the edge; seeing it costs 2 sync cycles plus 1 detect cycle.
    localparam int FRAME_TICKS = 8 + 16 * 8 + 12;
    localparam int DETECT_CYCLES = 3;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         tick;
        int         lat;
    } frame_t;

    frame_t     got_q[$];
    frame_t     exp_q[$];
    int         total = 0;
    int         passed = 0;
    int         tick_div = 4;
    int         div_cnt = 0;
    int         tick_total = 0;
    int         multi_pulse = 0;
    logic       prev_done = 1'b0;
    logic [7:0] last_data = 8'h00;

    always #5 clk_i = ~clk_i;

    // Tick generator: one pulse every tick_div clocks, updated off the active edge.
    always @(negedge clk_i) begin
        if (div_cnt >= tick_div - 1) begin
            div_cnt = 0;
            sample_tick_i = 1'b1;
        end else begin
            div_cnt = div_cnt + 1;
            sample_tick_i = 1'b0;
        end
    end

    // Free-running tick count used as the time base for latency.
    always @(posedge clk_i) begin
        if (sample_tick_i) tick_total <= tick_total + 1;
    end

    // Output monitor: records every done pulse and flags pulses wider than one cycle.
    always @(negedge clk_i) begin
        frame_t f;
        if (rx_done_tick_o === 1'b1) begin
            f.data = rx_data_o;
            f.err  = frame_err_o;
            f.tick = tick_total;
            f.lat  = 0;
            got_q.push_back(f);
            if (prev_done) multi_pulse = multi_pulse + 1;
        end
        prev_done = (rx_done_tick_o === 1'b1);
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_tick();
        do @(posedge clk_i); while (sample_tick_i !== 1'b1);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // Transmit one frame; abort_bit >= 0 asserts reset halfway through that data bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl,
                              input int stop_ticks, input int abort_bit);
        frame_t e;
        wait_tick();
        rx_i = 1'b0;
        e.data = data;
        e.err  = ~stop_lvl;
        e.tick = tick_total;
        e.lat  = FRAME_TICKS + DETECT_CYCLES / tick_div;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_i = data[i];
            if (i == abort_bit) begin
                wait_ticks(8);
                check("busy_mid_frame", rx_busy_o, 1'b1);
                rst_ni = 1'b0;
                rx_i = 1'b1;
                #1;
                check("rst_data", rx_data_o, 8'h00);
                check("rst_done", rx_done_tick_o, 1'b0);
                check("rst_err", frame_err_o, 1'b0);
                check("rst_busy", rx_busy_o, 1'b0);
                repeat (5) @(posedge clk_i);
                #1;
                check("rst_hold_data", rx_data_o, 8'h00);
                rst_ni = 1'b1;
                last_data = 8'h00;
                return;
            end
            wait_ticks(16);
        end
        rx_i = stop_lvl;
        wait_ticks(stop_ticks);
        rx_i = 1'b1;
        exp_q.push_back(e);
        last_data = data;
    endtask

    // Compare received frames with the model's predictions, then clear both.
    task automatic check_frames(input string tag);
        frame_t g;
        frame_t e;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, g.data, e.data);
            check({tag, "_err"}, g.err, e.err);
            check({tag, "_latency"}, g.tick - e.tick, e.lat);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rdata;
        logic       rstop;

        // Reset state.
        rst_ni = 1'b0;
        rx_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("reset_data", rx_data_o, 8'h00);
        check("reset_done", rx_done_tick_o, 1'b0);
        check("reset_err", frame_err_o, 1'b0);
        check("reset_busy", rx_busy_o, 1'b0);
        rst_ni = 1'b1;
        wait_ticks(20);

        // Single good frame, tick every 4 clocks.
        send_frame(8'h55, 1'b1, 16, -1);
        wait_ticks(20);
        check_frames("f55");
        check("f55_busy_idle", rx_busy_o, 1'b0);

        // Back-to-back frames with short stop bits.
        send_frame(8'hA5, 1'b1, 8, -1);
        send_frame(8'h00, 1'b1, 8, -1);
        send_frame(8'hFF, 1'b1, 8, -1);
        wait_ticks(20);
        check_frames("b2b");

        // Short low glitch on an idle line.
        wait_tick();
        rx_i = 1'b0;
        wait_ticks(4);
        rx_i = 1'b1;
        wait_ticks(30);
        check_frames("glitch");
        check("glitch_data_kept", rx_data_o, last_data);
        check("glitch_idle", rx_busy_o, 1'b0);

        // Framing error, then recovery with a good frame.
        send_frame(8'h3C, 1'b0, 6, -1);
        wait_ticks(20);
        check_frames("ferr");
        check("ferr_flag_held", frame_err_o, 1'b1);
        send_frame(8'h12, 1'b1, 16, -1);
        wait_ticks(20);
        check_frames("after_ferr");
        check("after_ferr_flag", frame_err_o, 1'b0);

        // Reset during data bit 3, then a clean frame.
        send_frame(8'hC3, 1'b1, 16, 3);
        wait_ticks(30);
        check_frames("aborted");
        send_frame(8'h7E, 1'b1, 16, -1);
        wait_ticks(20);
        check_frames("after_rst");
        check("after_rst_data", rx_data_o, 8'h7E);

        // Tick asserted on every clock.
        tick_div = 1;
        wait_ticks(20);
        send_frame(8'h81, 1'b1, 16, -1);
        wait_ticks(20);
        check_frames("tick_always");

        // Randomised frames, tick rates and stop bits.
        for (int n = 0; n < 8; n++) begin
            tick_div = $urandom_range(1, 4);
            wait_ticks(4);
            rdata = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            send_frame(rdata, rstop, rstop ? 16 : 6, -1);
            wait_ticks(20);
            check_frames("rand");
        end

        check("single_cycle_done", multi_pulse, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
